// File: rtl/univ_shift_reg.sv
// Universal N-bit shift register: hold, logical/arithmetic shift, rotate, load and clear,
// with a saturating count of shifts since the last load/clear/reset.
module univ_shift_reg #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SRL   = 3'b001;
  localparam logic [2:0] M_SLL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROR   = 3'b100;
  localparam logic [2:0] M_ROL   = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  logic [WIDTH-1:0] q_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    cnt_inc;

  // Every shift/rotate bumps the counter, pinned at WIDTH once a full word has moved.
  assign cnt_inc = (cnt < CNT_MAX) ? cnt + CW'(1) : cnt;

  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    unique case (mode)
      M_HOLD: begin
        q_nxt   = q;
        cnt_nxt = cnt;
      end
      M_SRL: begin
        q_nxt   = {sin_r, q[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      M_SLL: begin
        q_nxt   = {q[WIDTH-2:0], sin_l};
        cnt_nxt = cnt_inc;
      end
      M_LOAD: begin
        q_nxt   = d;
        cnt_nxt = '0;
      end
      M_ROR: begin
        q_nxt   = {q[0], q[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      M_ROL: begin
        q_nxt   = {q[WIDTH-2:0], q[WIDTH-1]};
        cnt_nxt = cnt_inc;
      end
      M_ASR: begin
        q_nxt   = {q[WIDTH-1], q[WIDTH-1:1]};
        cnt_nxt = cnt_inc;
      end
      M_CLEAR: begin
        q_nxt   = '0;
        cnt_nxt = '0;
      end
      default: begin
        q_nxt   = q;
        cnt_nxt = cnt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q   <= '0;
      cnt <= '0;
    end else if (en) begin
      q   <= q_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign so_r = q[0];
  assign so_l = q[WIDTH-1];
  assign done = (cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): each step queues the expected q/cnt
// and the result is popped and compared one cycle later.
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic         sin_r;
  logic         sin_l;
  logic [W-1:0] q;
  logic         so_r;
  logic         so_l;
  logic [3:0]   cnt;
  logic         done;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q_fifo[$];
  logic [3:0]   exp_c_fifo[$];

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l),
    .q(q), .so_r(so_r), .so_l(so_l), .cnt(cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation timed out");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] dd, input logic sr, input logic sl,
                      input logic [W-1:0] eq, input logic [3:0] ec);
    logic [W-1:0] pq;
    logic [3:0]   pc;
    rst   = r;
    en    = e;
    mode  = m;
    d     = dd;
    sin_r = sr;
    sin_l = sl;
    exp_q_fifo.push_back(eq);
    exp_c_fifo.push_back(ec);
    @(posedge clk);
    #1;
    pq = exp_q_fifo.pop_front();
    pc = exp_c_fifo.pop_front();
    chk({tag, ".q"},    32'(q),    32'(pq));
    chk({tag, ".cnt"},  32'(cnt),  32'(pc));
    chk({tag, ".done"}, 32'(done), 32'(pc == 4'd8));
    chk({tag, ".so_r"}, 32'(so_r), 32'(pq[0]));
    chk({tag, ".so_l"}, 32'(so_l), 32'(pq[W-1]));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = 3'b000; d = '0; sin_r = 1'b0; sin_l = 1'b0;
    @(negedge clk);

    // reset beats a simultaneous load of FF
    step("rst",    1, 1, 3'b011, 8'hFF, 0, 0, 8'h00, 4'd0);
    step("hold0",  0, 1, 3'b000, 8'hFF, 1, 1, 8'h00, 4'd0);

    // load A5, shift right with sin_r=1; so_r walks 1,0,1,0,0,1,0,1
    step("ldA5",   0, 1, 3'b011, 8'hA5, 0, 0, 8'hA5, 4'd0);
    step("srl1",   0, 1, 3'b001, 8'h00, 1, 0, 8'hD2, 4'd1);
    step("srl2",   0, 1, 3'b001, 8'h00, 1, 0, 8'hE9, 4'd2);
    step("srl3",   0, 1, 3'b001, 8'h00, 1, 0, 8'hF4, 4'd3);
    step("srl4",   0, 1, 3'b001, 8'h00, 1, 0, 8'hFA, 4'd4);
    step("srl5",   0, 1, 3'b001, 8'h00, 1, 0, 8'hFD, 4'd5);
    step("srl6",   0, 1, 3'b001, 8'h00, 1, 0, 8'hFE, 4'd6);
    step("srl7",   0, 1, 3'b001, 8'h00, 1, 0, 8'hFF, 4'd7);
    step("srl8",   0, 1, 3'b001, 8'h00, 1, 0, 8'hFF, 4'd8);
    step("srl9",   0, 1, 3'b001, 8'h00, 0, 0, 8'h7F, 4'd8);

    // rotate left with an enable gap; sin_l is X and must not matter
    step("ld81",   0, 1, 3'b011, 8'h81, 0, 0, 8'h81, 4'd0);
    step("rol1",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h03, 4'd1);
    step("rol2",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h06, 4'd2);
    step("rol3",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h0C, 4'd3);
    step("en0a",   0, 0, 3'b011, 8'h55, 1, 1, 8'h0C, 4'd3);
    step("en0b",   0, 0, 3'b111, 8'h55, 1, 1, 8'h0C, 4'd3);
    step("rol4",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h18, 4'd4);
    step("rol5",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h30, 4'd5);
    step("rol6",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h60, 4'd6);
    step("rol7",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'hC0, 4'd7);
    step("rol8",   0, 1, 3'b101, 8'h00, 0, 1'bx, 8'h81, 4'd8);

    // arithmetic shift right, negative then positive
    step("ld90",   0, 1, 3'b011, 8'h90, 0, 0, 8'h90, 4'd0);
    step("asr1",   0, 1, 3'b110, 8'h00, 1'bx, 0, 8'hC8, 4'd1);
    step("asr2",   0, 1, 3'b110, 8'h00, 1'bx, 0, 8'hE4, 4'd2);
    step("ld70",   0, 1, 3'b011, 8'h70, 0, 0, 8'h70, 4'd0);
    step("asr3",   0, 1, 3'b110, 8'h00, 1, 0, 8'h38, 4'd1);

    // clear then shift left with sin_l 1,1,0,1
    step("clr",    0, 1, 3'b111, 8'hAA, 1, 1, 8'h00, 4'd0);
    step("sll1",   0, 1, 3'b010, 8'h00, 1'bx, 1, 8'h01, 4'd1);
    step("sll2",   0, 1, 3'b010, 8'h00, 1'bx, 1, 8'h03, 4'd2);
    step("sll3",   0, 1, 3'b010, 8'h00, 1'bx, 0, 8'h06, 4'd3);
    step("sll4",   0, 1, 3'b010, 8'h00, 1'bx, 1, 8'h0D, 4'd4);

    // reset in the middle of a right-shift sequence
    step("ldF0",   0, 1, 3'b011, 8'hF0, 0, 0, 8'hF0, 4'd0);
    step("mid1",   0, 1, 3'b001, 8'h00, 0, 0, 8'h78, 4'd1);
    step("mid2",   0, 1, 3'b001, 8'h00, 0, 0, 8'h3C, 4'd2);
    step("mid3",   0, 1, 3'b001, 8'h00, 0, 0, 8'h1E, 4'd3);
    step("mid4",   0, 1, 3'b001, 8'h00, 0, 0, 8'h0F, 4'd4);
    step("mid5",   0, 1, 3'b001, 8'h00, 0, 0, 8'h07, 4'd5);
    step("midrst", 1, 1, 3'b001, 8'h00, 1, 0, 8'h00, 4'd0);
    step("postrst",0, 1, 3'b001, 8'h00, 1, 0, 8'h80, 4'd1);

    // rotate right a full word to reach done, then load while done is high
    step("ld01",   0, 1, 3'b011, 8'h01, 0, 0, 8'h01, 4'd0);
    step("ror1",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h80, 4'd1);
    step("ror2",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h40, 4'd2);
    step("ror3",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h20, 4'd3);
    step("ror4",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h10, 4'd4);
    step("ror5",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h08, 4'd5);
    step("ror6",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h04, 4'd6);
    step("ror7",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h02, 4'd7);
    step("ror8",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h01, 4'd8);
    step("ror9",   0, 1, 3'b100, 8'h00, 1'bx, 0, 8'h80, 4'd8);
    step("ld3C",   0, 1, 3'b011, 8'h3C, 0, 0, 8'h3C, 4'd0);
    step("hold1",  0, 1, 3'b000, 8'h00, 1, 1, 8'h3C, 4'd0);

    chk("fifo_empty", 32'(exp_q_fifo.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parametrised N-bit universal shift register and the successor to the single-bit D flip-flop.
- Adds synchronous reset, clock enable, and eight operating modes: hold, logical shift, rotate, arithmetic shift, parallel load and clear.
- Tracks shifts since the last load, so the block can serialise or deserialise a word without an external counter.
- Used as the datapath register for serial links and bit-serial arithmetic in the sequential library.

Parameters:
- WIDTH, 8, register width in bits; legal range 2 to 64.
- CW, $clog2(WIDTH+1), width of the shift counter; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset; sampled on the rising edge of clk; highest priority.
- en  input  1  clock enable; when 0, all state holds regardless of mode.
- mode  input  3  operation select (encoding under Behaviour).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering at the MSB on a right shift.
- sin_l  input  1  serial input entering at the LSB on a left shift.
- q  output  WIDTH  register contents.
- so_r  output  1  equals q[0], the bit leaving on a right shift; combinational from q.
- so_l  output  1  equals q[WIDTH-1], the bit leaving on a left shift; combinational from q.
- cnt  output  CW  number of shift/rotate operations since the last load, clear or reset; saturates at WIDTH.
- done  output  1  high when cnt == WIDTH; combinational from cnt.

Behaviour:
- Priority at each rising edge: rst, then en, then mode.
- rst=1:
  - q <= 0, cnt <= 0; therefore so_r=0, so_l=0, done=0.
  - Overrides en and mode.
  - Reset in the middle of a shift sequence discards the contents; the next cycle starts from 0.
- rst=0, en=0: q and cnt hold. No other side effects.
- rst=0, en=1, mode encoding:
  - 000 hold: q and cnt unchanged.
  - 001 shift right logical: q <= {sin_r, q[WIDTH-1:1]}.
  - 010 shift left logical: q <= {q[WIDTH-2:0], sin_l}.
  - 011 parallel load: q <= d; cnt <= 0.
  - 100 rotate right: q <= {q[0], q[WIDTH-1:1]}; sin_r ignored.
  - 101 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; sin_l ignored.
  - 110 arithmetic shift right: q <= {q[WIDTH-1], q[WIDTH-1:1]}; sign bit replicated; sin_r ignored.
  - 111 clear: q <= 0; cnt <= 0.
- Counter rules:
  - Modes 001, 010, 100, 101 and 110 increment cnt by 1 when cnt < WIDTH.
  - At cnt == WIDTH, cnt holds (saturates); the shift on q still executes.
  - Load and clear zero cnt on the same edge that updates q.
  - Hold leaves cnt unchanged.
- Latency:
  - One cycle from the mode/data sample to the q update.
  - so_r, so_l and done follow q/cnt with zero combinational delay; they are not registered.
- Boundaries:
  - A load in the same cycle that done is high reloads q and clears cnt; done drops on the next edge.
  - After WIDTH consecutive right shifts following a load, q holds exactly the last WIDTH sin_r bits (first bit at q[0]) and done=1.
  - After WIDTH rotates, q equals the loaded value.
  - The mode input has no illegal values.
  - X on sin_r or sin_l is ignored in modes that do not use it.

Test Plan:
- WIDTH=8.
- Reset: drive rst=1 for one edge with en=1, mode=011, d=8'hFF -> q=8'h00, cnt=0, done=0. Reset has priority over load.
- Load then shift right: load d=8'hA5, then 8 cycles of mode=001 with sin_r=1 -> so_r emits 1,0,1,0,0,1,0,1 (LSB first); final q=8'hFF, cnt=8, done=1. A 9th shift keeps cnt=8.
- Rotate left and enable: load 8'h81, mode=101 for 3 edges -> q=8'h0C, cnt=3. Deassert en for 2 edges -> q and cnt unchanged. Continue 5 more rotates -> q=8'h81, done=1.
- Arithmetic shift right: load 8'h90, mode=110 for 2 edges -> q=8'hE4. Load 8'h70, one ASR -> q=8'h38.
- Shift left with serial input: after clear (mode=111 -> q=0, cnt=0), mode=010 with sin_l sequence 1,1,0,1 -> q=8'h0D, so_l=0, cnt=4.
- Mid-sequence reset and load at done: after 5 right shifts assert rst -> q=0, cnt=0 on that edge. Separately, with done=1, load 8'h3C -> q=8'h3C, cnt=0, done=0 the next cycle.
